pipeline_latealu: RTL and testbench
===================================

// Module: pipeline_latealu
// PURPOSE
//  Pipeline stage directly downstream of the ALU stage. Consumes the ALU's registered outputs and the LateALU request.
//  Executes barrel shifts (sll/srl/sra), and optionally an iterative 32x32 multiply, then forwards rd index/value,
//  memop_disable and exception to the memory stage. Raises stall while a multi-cycle op is in flight.
// PARAMETERS
//  MUL_STEPS  32  iterations of the shift-add multiplier; fixed at 32 for a full-width result
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  rd_index_in     in   5   destination register from ALU stage (0 = no writeback)
//  rd_value_in     in   32  result from ALU stage
//  memop_disable_in in  1   memop suppress flag from ALU stage
//  exception_in    in   3   exception code from ALU stage (0 = none)
//  latealu_enable  in   1   LateALU request valid
//  latealu_op      in   6   1=sll 2=srl 3=sra 4=mul (low 32 bits of product)
//  latealu_a0      in   32  shift/multiply operand
//  latealu_a1      in   32  shift amount in [4:0] (bits [31:5] ignored) / multiplier
//  rd_index        out  5   registered destination index to memory stage
//  rd_value        out  32  registered result
//  memop_disable   out  1   registered memop suppress
//  exception       out  3   registered exception code
//  stall           out  1   combinational; upstream holds all inputs while high
// BEHAVIOUR
//  - Reset: rd_index=0, rd_value=0, memop_disable=0, exception=0, FSM=IDLE, counter=0, stall=0.
//  - Priority each cycle: rst > exception_in!=0 > latealu_enable > pass-through.
//  - exception_in!=0: exception<=exception_in, rd_index<=0, rd_value<=0, memop_disable<=1; LateALU not evaluated.
//  - latealu_enable=0: rd_index/rd_value/memop_disable/exception <= *_in, latency 1.
//  - Shift ops (latency 1): rd_index<=rd_index_in, memop_disable<=memop_disable_in.
//    sll: a0<<a1[4:0]; srl: logical right shift; sra: arithmetic right shift (sign fill from a0[31]).
//    Shift by 0 returns a0 unchanged.
//  - Unknown op, or op 4 without the macro: exception<=3'b001, rd_index<=0, rd_value<=0.
//  - FSM (mul only): IDLE -> MUL on accepted op 4; MUL -> IDLE when counter==31.
//    On entry, latch a0, a1, rd_index_in and memop_disable_in; set acc=0 and counter=0.
//    In MUL, each cycle: acc += a1_latched[counter] ? (a0_latched<<counter) : 0; counter++.
//    The cycle after counter reaches 31, write rd_value=acc[31:0] (mod 2^32; no overflow exception) and rd_index=latched index.
//  - stall = !rst && ((IDLE && enable && op==4 && exception_in==0) || (MUL && counter!=31)).
//    In the final MUL cycle stall=0, so upstream advances on the same edge that writes the result.
//  - Mul latency: 33 edges from presentation to valid output. Bubbles during the 32 prior edges:
//    rd_index=0, rd_value=0, memop_disable=1, exception=0. Inputs are ignored while in MUL.
//  - Reset in MUL: the op is abandoned, FSM=IDLE, no result is written, stall drops in the reset cycle.
// CONFIGURATION
//  PIPELINE_LATEALU_MUL_EN defined: op 4 is implemented by the FSM above.
//  Not defined: no FSM or accumulator; stall is tied 0; op 4 takes the unknown-op path (exception 3'b001).
// TESTING
//  1. enable=1 op=1 a0=1 a1=4 rd_index_in=8 -> next edge rd_index=8 rd_value=16, stall=0.
//  2. op=3 a0=0x80000000 a1=0xFFFFFFE4 -> rd_value=0xF8000000 (only a1[4:0]=4 used); op=2 same -> 0x08000000.
//  3. enable=0 rd_index_in=5 rd_value_in=0x1234 -> rd_index=5 rd_value=0x1234; exception_in=3'b010 -> exception=2, rd_index=0, memop_disable=1.
//  4. op=9 -> exception=3'b001, rd_index=0; with macro undefined, op=4 -> same.
//  5. MUL_EN: op=4 a0=7 a1=6 rd_index_in=3 -> stall high for 32 cycles, bubbles, then rd_index=3 rd_value=42;
//     a0=a1=0xFFFFFFFF -> rd_value=1.
//  6. MUL_EN: rst pulsed at counter=10 -> outputs zero, stall=0, FSM=IDLE; a following sll completes in 1 cycle.

Source files
------------

// File: rtl/pipeline_latealu_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_latealu_if
//  Description : ALU-stage -> LateALU-stage bundle plus results to memory stage
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_latealu_if;
    logic [4:0]  rd_index_in;
    logic [31:0] rd_value_in;
    logic        memop_disable_in;
    logic [2:0]  exception_in;
    logic        latealu_enable;
    logic [5:0]  latealu_op;
    logic [31:0] latealu_a0;
    logic [31:0] latealu_a1;
    logic [4:0]  rd_index;
    logic [31:0] rd_value;
    logic        memop_disable;
    logic [2:0]  exception;
    logic        stall;

    modport master (
        output rd_index_in, rd_value_in, memop_disable_in, exception_in,
               latealu_enable, latealu_op, latealu_a0, latealu_a1,
        input  rd_index, rd_value, memop_disable, exception, stall
    );

    modport slave (
        input  rd_index_in, rd_value_in, memop_disable_in, exception_in,
               latealu_enable, latealu_op, latealu_a0, latealu_a1,
        output rd_index, rd_value, memop_disable, exception, stall
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_latealu.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_latealu
//  Description : Late-ALU stage: barrel shifts and optional iterative multiply
//                (multiply enabled by defining PIPELINE_LATEALU_MUL_EN)
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_latealu #(
    parameter int MUL_STEPS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_latealu_if.slave    bus
);
    localparam logic [5:0] c_OP_SLL = 6'd1;
    localparam logic [5:0] c_OP_SRL = 6'd2;
    localparam logic [5:0] c_OP_SRA = 6'd3;
    localparam logic [5:0] c_OP_MUL = 6'd4;
    localparam logic [4:0] c_LAST   = 5'(MUL_STEPS - 1);

    logic [4:0]  rd_index_q, rd_index_d;
    logic [31:0] rd_value_q, rd_value_d;
    logic        memop_disable_q, memop_disable_d;
    logic [2:0]  exception_q, exception_d;
    logic        w_stall;

    logic [4:0]  w_shamt;
    logic [31:0] w_shift_res;
    logic        w_is_shift;

    assign w_shamt = bus.latealu_a1[4:0];

    always_comb begin
        w_shift_res = '0;
        w_is_shift  = 1'b0;
        case (bus.latealu_op)
            c_OP_SLL: begin
                w_is_shift  = 1'b1;
                w_shift_res = bus.latealu_a0 << w_shamt;
            end
            c_OP_SRL: begin
                w_is_shift  = 1'b1;
                w_shift_res = bus.latealu_a0 >> w_shamt;
            end
            c_OP_SRA: begin
                w_is_shift  = 1'b1;
                w_shift_res = 32'($signed(bus.latealu_a0) >>> w_shamt);
            end
            default: ;
        endcase
    end

`ifdef PIPELINE_LATEALU_MUL_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  counter_q, counter_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] a0_q, a0_d;
    logic [31:0] a1_q, a1_d;
    logic [4:0]  idx_lat_q, idx_lat_d;
    logic        md_lat_q, md_lat_d;
    logic        w_accept;
    logic [31:0] w_term;

    assign w_accept = (state_q == S_IDLE) && (bus.exception_in == 3'd0) &&
                      bus.latealu_enable && (bus.latealu_op == c_OP_MUL);
    assign w_term   = a1_q[counter_q] ? (a0_q << counter_q) : 32'd0;
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{bus.latealu_a1[31:5], c_LAST};
`endif

    always_comb begin
        rd_index_d      = bus.rd_index_in;
        rd_value_d      = bus.rd_value_in;
        memop_disable_d = bus.memop_disable_in;
        exception_d     = bus.exception_in;
        w_stall         = 1'b0;

        if (bus.exception_in != 3'd0) begin
            rd_index_d      = 5'd0;
            rd_value_d      = 32'd0;
            memop_disable_d = 1'b1;
        end else if (bus.latealu_enable) begin
            if (w_is_shift) begin
                rd_value_d  = w_shift_res;
                exception_d = 3'd0;
            end else begin
                rd_index_d      = 5'd0;
                rd_value_d      = 32'd0;
                memop_disable_d = 1'b1;
                exception_d     = 3'b001;
            end
        end

`ifdef PIPELINE_LATEALU_MUL_EN
        state_d   = state_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        a0_d      = a0_q;
        a1_d      = a1_q;
        idx_lat_d = idx_lat_q;
        md_lat_d  = md_lat_q;

        if (w_accept) begin
            state_d         = S_MUL;
            a0_d            = bus.latealu_a0;
            a1_d            = bus.latealu_a1;
            idx_lat_d       = bus.rd_index_in;
            md_lat_d        = bus.memop_disable_in;
            acc_d           = 32'd0;
            counter_d       = 5'd0;
            rd_index_d      = 5'd0;
            rd_value_d      = 32'd0;
            memop_disable_d = 1'b1;
            exception_d     = 3'd0;
            w_stall         = 1'b1;
        end

        // Upstream inputs are frozen while iterating; only internal state matters.
        if (state_q == S_MUL) begin
            acc_d           = acc_q + w_term;
            counter_d       = counter_q + 5'd1;
            rd_index_d      = 5'd0;
            rd_value_d      = 32'd0;
            memop_disable_d = 1'b1;
            exception_d     = 3'd0;
            if (counter_q == c_LAST) begin
                state_d         = S_IDLE;
                rd_index_d      = idx_lat_q;
                rd_value_d      = acc_q + w_term;
                memop_disable_d = md_lat_q;
            end else begin
                w_stall = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_index_q      <= 5'd0;
            rd_value_q      <= 32'd0;
            memop_disable_q <= 1'b0;
            exception_q     <= 3'd0;
        end else begin
            rd_index_q      <= rd_index_d;
            rd_value_q      <= rd_value_d;
            memop_disable_q <= memop_disable_d;
            exception_q     <= exception_d;
        end
    end

`ifdef PIPELINE_LATEALU_MUL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= 5'd0;
            acc_q     <= 32'd0;
            a0_q      <= 32'd0;
            a1_q      <= 32'd0;
            idx_lat_q <= 5'd0;
            md_lat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            a0_q      <= a0_d;
            a1_q      <= a1_d;
            idx_lat_q <= idx_lat_d;
            md_lat_q  <= md_lat_d;
        end
    end
`endif

    assign bus.rd_index      = rd_index_q;
    assign bus.rd_value      = rd_value_q;
    assign bus.memop_disable = memop_disable_q;
    assign bus.exception     = exception_q;
    assign bus.stall         = !rst && w_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_latealu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_latealu
//  Description : Directed + random scoreboard bench for pipeline_latealu
//                (multiply steps active when PIPELINE_LATEALU_MUL_EN defined)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_latealu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_latealu_if bus ();

    pipeline_latealu #(.MUL_STEPS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] val;
        logic        md;
        logic        md_dc;
        logic [2:0]  exc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [5:0] op, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [4:0] idx_in,
                         input logic [31:0] val_in, input logic md_in, input logic [2:0] exc_in);
        bus.latealu_enable   = en;
        bus.latealu_op       = op;
        bus.latealu_a0       = a0;
        bus.latealu_a1       = a1;
        bus.rd_index_in      = idx_in;
        bus.rd_value_in      = val_in;
        bus.memop_disable_in = md_in;
        bus.exception_in     = exc_in;
    endtask

    task automatic push(input logic [4:0] idx, input logic [31:0] val, input logic md,
                        input logic md_dc, input logic [2:0] exc);
        exp_t e;
        e.idx = idx; e.val = val; e.md = md; e.md_dc = md_dc; e.exc = exc;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s observed=output expected=queued_entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".rd_index"}, 32'(bus.rd_index), 32'(e.idx));
            chk({tag, ".rd_value"}, bus.rd_value, e.val);
            if (!e.md_dc) chk({tag, ".memop_disable"}, 32'(bus.memop_disable), 32'(e.md));
            chk({tag, ".exception"}, 32'(bus.exception), 32'(e.exc));
        end
    endtask

    // Check combinational stall, take one edge, then compare against scoreboard.
    task automatic edge_check(input string tag, input logic exp_stall);
        #1;
        chk({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] shift_model(input logic [5:0] op, input logic [31:0] a,
                                                input logic [4:0] s);
        logic [31:0] fill;
        fill = (s == 5'd0) ? 32'd0 : ~(32'hFFFF_FFFF >> s);
        case (op)
            6'd1:    return a << s;
            6'd2:    return a >> s;
            default: return (a >> s) | (a[31] ? fill : 32'd0);
        endcase
    endfunction

`ifdef PIPELINE_LATEALU_MUL_EN
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] idx);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        drive(1'b1, 6'd4, a, b, idx, 32'h5555_5555, 1'b0, 3'd0);
        push(idx, prod[31:0], 1'b0, 1'b0, 3'd0);
        #1;
        chk({tag, ".stall_accept"}, 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        // Scribble the inputs: they must be ignored while iterating.
        drive(1'b1, 6'd1, 32'hFFFF_FFFF, 32'd3, 5'd17, 32'hABCD, 1'b0, 3'd5);
        for (int k = 1; k <= 32; k++) begin
            #1;
            chk({tag, ".bub_idx"}, 32'(bus.rd_index), 32'd0);
            chk({tag, ".bub_val"}, bus.rd_value, 32'd0);
            chk({tag, ".bub_md"}, 32'(bus.memop_disable), 32'd1);
            chk({tag, ".bub_exc"}, 32'(bus.exception), 32'd0);
            chk({tag, ".stall"}, 32'(bus.stall), (k == 32) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
        end
        check_outputs(tag);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rop;
        logic [4:0]  ridx;

        rst = 1'b1;
        drive(1'b1, 6'd4, 32'd7, 32'd6, 5'd3, 32'h1111, 1'b1, 3'd0);
        #1;
        chk("reset.stall_in_rst", 32'(bus.stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rd_index", 32'(bus.rd_index), 32'd0);
        chk("reset.rd_value", bus.rd_value, 32'd0);
        chk("reset.memop_disable", 32'(bus.memop_disable), 32'd0);
        chk("reset.exception", 32'(bus.exception), 32'd0);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 3'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        drive(1'b1, 6'd1, 32'd1, 32'd4, 5'd8, 32'hDEAD, 1'b0, 3'd0);
        push(5'd8, 32'd16, 1'b0, 1'b0, 3'd0);
        edge_check("sll_basic", 1'b0);

        drive(1'b1, 6'd3, 32'h8000_0000, 32'hFFFF_FFE4, 5'd2, 32'd0, 1'b1, 3'd0);
        push(5'd2, 32'hF800_0000, 1'b1, 1'b0, 3'd0);
        edge_check("sra_neg", 1'b0);

        drive(1'b1, 6'd2, 32'h8000_0000, 32'hFFFF_FFE4, 5'd2, 32'd0, 1'b0, 3'd0);
        push(5'd2, 32'h0800_0000, 1'b0, 1'b0, 3'd0);
        edge_check("srl_basic", 1'b0);

        drive(1'b1, 6'd1, 32'hDEAD_BEEF, 32'h0000_0020, 5'd9, 32'd0, 1'b0, 3'd0);
        push(5'd9, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd0);
        edge_check("sll_by0", 1'b0);

        drive(1'b1, 6'd3, 32'h8123_4567, 32'd0, 5'd10, 32'd0, 1'b0, 3'd0);
        push(5'd10, 32'h8123_4567, 1'b0, 1'b0, 3'd0);
        edge_check("sra_by0", 1'b0);

        drive(1'b1, 6'd1, 32'd3, 32'd31, 5'd11, 32'd0, 1'b0, 3'd0);
        push(5'd11, 32'h8000_0000, 1'b0, 1'b0, 3'd0);
        edge_check("sll_by31", 1'b0);

        drive(1'b1, 6'd3, 32'h7FFF_FFFF, 32'd31, 5'd12, 32'd0, 1'b0, 3'd0);
        push(5'd12, 32'd0, 1'b0, 1'b0, 3'd0);
        edge_check("sra_pos31", 1'b0);

        drive(1'b0, 6'd1, 32'd1, 32'd1, 5'd5, 32'h1234, 1'b1, 3'd0);
        push(5'd5, 32'h1234, 1'b1, 1'b0, 3'd0);
        edge_check("passthru", 1'b0);

        drive(1'b1, 6'd1, 32'd1, 32'd4, 5'd7, 32'h9999, 1'b0, 3'b010);
        push(5'd0, 32'd0, 1'b1, 1'b0, 3'b010);
        edge_check("exc_in", 1'b0);

        drive(1'b1, 6'd9, 32'd1, 32'd4, 5'd7, 32'h9999, 1'b0, 3'd0);
        push(5'd0, 32'd0, 1'b0, 1'b1, 3'b001);
        edge_check("unknown_op", 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rop  = 6'($urandom_range(1, 3));
            ridx = 5'($urandom_range(1, 31));
            drive(1'b1, rop, ra, rb, ridx, 32'h0, 1'(i), 3'd0);
            push(ridx, shift_model(rop, ra, rb[4:0]), 1'(i), 1'b0, 3'd0);
            edge_check("rand_shift", 1'b0);
        end

`ifdef PIPELINE_LATEALU_MUL_EN
        run_mul("mul_7x6", 32'd7, 32'd6, 5'd3);
        run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20);
        run_mul("mul_rand", 32'h1234_5678, 32'h9ABC_DEF1, 5'd31);

        drive(1'b1, 6'd4, 32'd123, 32'd456, 5'd6, 32'd0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        chk("mulrst.stall_before", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mulrst.stall_in_rst", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        chk("mulrst.rd_index", 32'(bus.rd_index), 32'd0);
        chk("mulrst.rd_value", bus.rd_value, 32'd0);
        chk("mulrst.memop_disable", 32'(bus.memop_disable), 32'd0);
        rst = 1'b0;
        drive(1'b1, 6'd1, 32'd1, 32'd5, 5'd4, 32'd0, 1'b0, 3'd0);
        push(5'd4, 32'd32, 1'b0, 1'b0, 3'd0);
        edge_check("mulrst.sll_after", 1'b0);
`else
        drive(1'b1, 6'd4, 32'd7, 32'd6, 5'd3, 32'd0, 1'b0, 3'd0);
        push(5'd0, 32'd0, 1'b0, 1'b1, 3'b001);
        edge_check("mul_disabled", 1'b0);
`endif

        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 3'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
